// File: rtl/instr_fetch_mem_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem_if
//
// Purpose: bundles the loader and fetch signals of instr_fetch_mem so the
// memory and its user connect through a single port.
//
// Signals:
//   load_start  master->slave  rewind the load pointer, clear load_ovf
//   load_en     master->slave  store load_data at the load pointer
//   load_data   master->slave  word to store (WORD_W)
//   load_full   slave->master  load pointer has reached DEPTH
//   load_ovf    slave->master  sticky: a store was attempted while full
//   fetch_req   master->slave  request a fetch of pc
//   fetch_ready slave->master  fetch can be accepted this cycle
//   pc          master->slave  fetch address (ADDR_W)
//   fetch_valid slave->master  one-cycle pulse, response fields are valid
//   instr       slave->master  raw fetched word (WORD_W)
//   opcode      slave->master  top OP_W bits of instr
//   label       slave->master  bottom LBL_W bits of instr
//   fetch_err   slave->master  00 ok, 01 out of range, 10 unwritten, 11 parity
//
// Fetch handshake: a request transfers on a rising edge where fetch_req and
// fetch_ready are both 1. The requester keeps fetch_req and pc stable until
// that edge. fetch_ready drops whenever the loader is active (load_en or
// load_start), so loads always win. The response appears after the accept
// edge as a single-cycle fetch_valid pulse; there is no response backpressure.
// ----------------------------------------------------------------------------
interface instr_fetch_mem_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 4,
    parameter int LBL_W  = 6
);
    logic              load_start;
    logic              load_en;
    logic [WORD_W-1:0] load_data;
    logic              load_full;
    logic              load_ovf;
    logic              fetch_req;
    logic              fetch_ready;
    logic [ADDR_W-1:0] pc;
    logic              fetch_valid;
    logic [WORD_W-1:0] instr;
    logic [OP_W-1:0]   opcode;
    logic [LBL_W-1:0]  label;
    logic [1:0]        fetch_err;

    modport slave (
        input  load_start, load_en, load_data, fetch_req, pc,
        output load_full, load_ovf, fetch_ready, fetch_valid,
               instr, opcode, label, fetch_err
    );

    modport master (
        output load_start, load_en, load_data, fetch_req, pc,
        input  load_full, load_ovf, fetch_ready, fetch_valid,
               instr, opcode, label, fetch_err
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem
//
// Purpose: instruction memory with a streaming program loader and a
// registered, handshaked fetch port (one-cycle latency, one fetch per cycle).
// Each fetch returns the raw word, its opcode and label fields, and an error
// code. Words become fetchable only after they have been loaded since the
// last reset.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high
//   bus        instr_fetch_mem_if.slave (loader + fetch signals)
//   dbg_state  fetch FSM state: 0 = IDLE, 1 = RESP
//
// Build option: define INSTR_FETCH_MEM_PARITY_EN to store an even-parity bit
// per word and report fetch_err = 11 on a mismatch. Without it no parity is
// stored and code 11 never occurs.
// ----------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int OP_W   = 4,
    parameter int LBL_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    instr_fetch_mem_if.slave  bus,
    output logic              dbg_state
);
    // Index width for the storage arrays; fits in ADDR_W because
    // DEPTH <= 2**ADDR_W.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_RANGE  = 2'b01;
    localparam logic [1:0] ERR_UNWRIT = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Storage is deliberately not reset; the written vector tells valid
    // words from power-up garbage.
    logic [WORD_W-1:0] mem [DEPTH];
`ifdef INSTR_FETCH_MEM_PARITY_EN
    logic [DEPTH-1:0]  par_mem;
    localparam logic [1:0] ERR_PARITY = 2'b11;
`endif

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  written_q, written_d;
    logic [ADDR_W:0]   lptr_q, lptr_d;
    logic              load_full_q, load_full_d;
    logic              load_ovf_q, load_ovf_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [1:0]        err_q, err_d;

    logic              fetch_ready;
    logic              fetch_accept;
    logic              load_write;
    logic              pc_in_range;
    logic [IDX_W-1:0]  lptr_idx;
    logic [IDX_W-1:0]  pc_idx;

    assign fetch_ready  = !bus.load_en && !bus.load_start;
    assign fetch_accept = bus.fetch_req && fetch_ready;
    // load_start suppresses a simultaneous write; a full pointer drops it.
    assign load_write   = bus.load_en && !bus.load_start && (lptr_q < DEPTH_L);
    assign pc_in_range  = ({1'b0, bus.pc} < DEPTH_L);
    assign lptr_idx     = lptr_q[IDX_W-1:0];
    assign pc_idx       = bus.pc[IDX_W-1:0];

    always_comb begin
        state_d   = IDLE;
        written_d = written_q;
        lptr_d    = lptr_q;
        load_ovf_d = load_ovf_q;
        instr_d   = instr_q;
        err_d     = err_q;

        if (bus.load_start) begin
            lptr_d     = '0;
            load_ovf_d = 1'b0;
        end else if (bus.load_en) begin
            if (load_write) begin
                written_d[lptr_idx] = 1'b1;
                lptr_d              = lptr_q + 1'b1;
            end else begin
                load_ovf_d = 1'b1;
            end
        end
        load_full_d = (lptr_d == DEPTH_L);

        // Fetch and load never overlap (fetch_ready), so reading mem here
        // never sees a same-cycle write.
        if (fetch_accept) begin
            state_d = RESP;
            if (!pc_in_range) begin
                instr_d = '0;
                err_d   = ERR_RANGE;
            end else if (!written_q[pc_idx]) begin
                instr_d = '0;
                err_d   = ERR_UNWRIT;
            end else begin
                instr_d = mem[pc_idx];
                err_d   = ERR_OK;
`ifdef INSTR_FETCH_MEM_PARITY_EN
                if ((^mem[pc_idx]) != par_mem[pc_idx]) begin
                    err_d = ERR_PARITY;
                end
`endif
            end
        end
    end

    // FSM, loader bookkeeping and registered response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            written_q   <= '0;
            lptr_q      <= '0;
            load_full_q <= 1'b0;
            load_ovf_q  <= 1'b0;
            instr_q     <= '0;
            err_q       <= ERR_OK;
        end else begin
            state_q     <= state_d;
            written_q   <= written_d;
            lptr_q      <= lptr_d;
            load_full_q <= load_full_d;
            load_ovf_q  <= load_ovf_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (load_write) begin
            mem[lptr_idx] <= bus.load_data;
`ifdef INSTR_FETCH_MEM_PARITY_EN
            par_mem[lptr_idx] <= ^bus.load_data;
`endif
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.fetch_valid = (state_q == RESP);
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[WORD_W-1 -: OP_W];
    assign bus.label       = instr_q[LBL_W-1:0];
    assign bus.fetch_err   = err_q;
    assign bus.load_full   = load_full_q;
    assign bus.load_ovf    = load_ovf_q;
    assign dbg_state       = (state_q == RESP);
endmodule

// File: tb/tb_instr_fetch_mem.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_mem
//
// Self-checking bench for instr_fetch_mem with default parameters. A
// behavioural model (arrays for memory, written flags and a load pointer)
// predicts every cycle; fetch responses go through an expected queue.
// Directed sequences cover reset, load/fetch, a constant vector table,
// loader priority, overflow and parity, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_instr_fetch_mem;
    localparam int WORD_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 64;
    localparam int OP_W   = 4;
    localparam int LBL_W  = 6;
    localparam int RSP_W  = WORD_W + 2;
    localparam logic [WORD_W-1:0] LBL_MASK = WORD_W'((1 << LBL_W) - 1);
`ifdef INSTR_FETCH_MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dbg_state;

    always #5 clock = ~clock;

    instr_fetch_mem_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .LBL_W(LBL_W)) bus ();

    instr_fetch_mem #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OP_W(OP_W), .LBL_W(LBL_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [WORD_W-1:0] ref_mem     [DEPTH];
    bit                ref_written [DEPTH];
    bit                ref_par_bad [DEPTH];
    int                ref_lptr;
    bit                ref_ovf;
    logic [WORD_W-1:0] ref_instr;
    logic [1:0]        ref_err;
    logic [RSP_W-1:0]  exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_written[i] = 1'b0;
        ref_lptr  = 0;
        ref_ovf   = 1'b0;
        ref_instr = '0;
        ref_err   = 2'b00;
        exp_q.delete();
    endtask

    function automatic logic [RSP_W-1:0] model_fetch(input int p);
        if (p >= DEPTH) return {2'b01, {WORD_W{1'b0}}};
        if (!ref_written[p]) return {2'b10, {WORD_W{1'b0}}};
        if (PAR_EN && ref_par_bad[p]) return {2'b11, ref_mem[p]};
        return {2'b00, ref_mem[p]};
    endfunction

    task automatic model_load(input logic start, input logic en, input logic [WORD_W-1:0] data);
        if (start) begin
            ref_lptr = 0;
            ref_ovf  = 1'b0;
        end else if (en) begin
            if (ref_lptr < DEPTH) begin
                ref_mem[ref_lptr]     = data;
                ref_written[ref_lptr] = 1'b1;
                ref_par_bad[ref_lptr] = 1'b0;
                ref_lptr++;
            end else begin
                ref_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("load_full", 32'(bus.load_full), 32'(ref_lptr == DEPTH));
        check("load_ovf",  32'(bus.load_ovf), 32'(ref_ovf));
        check("instr",     32'(bus.instr), 32'(ref_instr));
        check("fetch_err", 32'(bus.fetch_err), 32'(ref_err));
        check("opcode",    32'(bus.opcode), 32'(ref_instr >> (WORD_W - OP_W)));
        check("label",     32'(bus.label), 32'(ref_instr & LBL_MASK));
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; drives one cycle and checks the
    // outputs one time unit after the next rising edge.
    task automatic do_cycle(input logic start, input logic en, input logic [WORD_W-1:0] data,
                            input logic req, input int p);
        bit acc;
        logic [RSP_W-1:0] e;
        bus.load_start = start;
        bus.load_en    = en;
        bus.load_data  = data;
        bus.fetch_req  = req;
        bus.pc         = ADDR_W'(p);
        #1;
        check("fetch_ready", 32'(bus.fetch_ready), 32'(!en && !start));
        acc = req && !en && !start;
        if (acc) exp_q.push_back(model_fetch(p));
        model_load(start, en, data);
        @(posedge clock);
        #1;
        check("fetch_valid", 32'(bus.fetch_valid), 32'(acc));
        check("dbg_state",   32'(dbg_state), 32'(acc));
        if (acc && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ref_instr = e[WORD_W-1:0];
            ref_err   = e[RSP_W-1:WORD_W];
        end
        check_outputs();
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 1'b0, '0, 1'b0, 0);
    endtask

    task automatic load_word(input logic [WORD_W-1:0] data);
        do_cycle(1'b0, 1'b1, data, 1'b0, 0);
    endtask

    task automatic fetch(input int p);
        do_cycle(1'b0, 1'b0, '0, 1'b1, p);
    endtask

    // Asynchronous reset asserted between edges with a fetch pending.
    task automatic mid_cycle_reset();
        bus.fetch_req = 1'b1;
        bus.pc        = '0;
        #3;
        reset = 1'b1;
        #1;
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_instr",       32'(bus.instr), 32'd0);
        check("rst_fetch_err",   32'(bus.fetch_err), 32'd0);
        check("rst_opcode",      32'(bus.opcode), 32'd0);
        check("rst_label",       32'(bus.label), 32'd0);
        check("rst_load_full",   32'(bus.load_full), 32'd0);
        check("rst_load_ovf",    32'(bus.load_ovf), 32'd0);
        check("rst_state",       32'(dbg_state), 32'd0);
        #10;
        bus.fetch_req = 1'b0;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        check("rst_no_inflight", 32'(bus.fetch_valid), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int               pc;
        logic [WORD_W-1:0] exp_instr;
        logic [1:0]        exp_err;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main test ----------------
    initial begin
        logic [WORD_W-1:0] first_word;
        logic [WORD_W-1:0] r_data;
        logic r_start, r_en, r_req;
        int   r_pc;

        bus.load_start = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_data  = '0;
        bus.fetch_req  = 1'b0;
        bus.pc         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]     = 'x;
            ref_par_bad[i] = 1'b0;
        end
        model_reset();

        #1;
        check("init_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("init_instr",       32'(bus.instr), 32'd0);
        check("init_fetch_err",   32'(bus.fetch_err), 32'd0);
        check("init_load_full",   32'(bus.load_full), 32'd0);
        check("init_load_ovf",    32'(bus.load_ovf), 32'd0);
        #11;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Fetch of an unwritten word right after reset.
        fetch(0);
        check("unwritten_err", 32'(bus.fetch_err), 32'h2);

        // Load A5, 3C then fetch pc = 1.
        do_cycle(1'b1, 1'b0, '0, 1'b0, 0);
        load_word(8'hA5);
        load_word(8'h3C);
        fetch(1);
        check("pc1_valid",  32'(bus.fetch_valid), 32'd1);
        check("pc1_instr",  32'(bus.instr), 32'h3C);
        check("pc1_opcode", 32'(bus.opcode), 32'h3);
        check("pc1_label",  32'(bus.label), 32'h3C);
        check("pc1_err",    32'(bus.fetch_err), 32'h0);
        idle_cycle();

        // Back-to-back fetches from a constant table.
        vecs[0] = '{0,   8'hA5, 2'b00};
        vecs[1] = '{1,   8'h3C, 2'b00};
        vecs[2] = '{2,   8'h00, 2'b10};
        vecs[3] = '{63,  8'h00, 2'b10};
        vecs[4] = '{64,  8'h00, 2'b01};
        vecs[5] = '{200, 8'h00, 2'b01};
        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].pc);
            check("vec_valid", 32'(bus.fetch_valid), 32'd1);
            check("vec_instr", 32'(bus.instr), 32'(vecs[i].exp_instr));
            check("vec_err",   32'(bus.fetch_err), 32'(vecs[i].exp_err));
        end
        idle_cycle();

        // Loader priority: fetch held while loading, accepted once load_en drops.
        do_cycle(1'b0, 1'b1, 8'h11, 1'b1, 0);
        do_cycle(1'b0, 1'b1, 8'h22, 1'b1, 0);
        do_cycle(1'b0, 1'b1, 8'h33, 1'b1, 0);
        fetch(0);
        check("prio_accept_instr", 32'(bus.instr), 32'hA5);
        fetch(3);
        check("prio_loaded_word", 32'(bus.instr), 32'h22);

        // Reset mid-cycle with a fetch pending, then unwritten fetch.
        mid_cycle_reset();
        fetch(0);
        check("post_rst_err",   32'(bus.fetch_err), 32'h2);
        check("post_rst_instr", 32'(bus.instr), 32'h0);

        // Fill all words, then overflow.
        do_cycle(1'b1, 1'b0, '0, 1'b0, 0);
        first_word = WORD_W'($urandom);
        load_word(first_word);
        for (int i = 1; i < DEPTH; i++) load_word(WORD_W'($urandom));
        check("full_after_64", 32'(bus.load_full), 32'd1);
        check("no_ovf_at_64",  32'(bus.load_ovf), 32'd0);
        load_word(8'hFF);
        check("ovf_after_65", 32'(bus.load_ovf), 32'd1);
        fetch(0);
        check("mem0_kept", 32'(bus.instr), 32'(first_word));
        idle_cycle();
        do_cycle(1'b1, 1'b0, '0, 1'b0, 0);
        check("start_clears_ovf", 32'(bus.load_ovf), 32'd0);

        // Parity: corrupt one stored bit behind the loader's back.
        dut.mem[5] = dut.mem[5] ^ 8'h10;
        ref_mem[5] = ref_mem[5] ^ 8'h10;
        ref_par_bad[5] = 1'b1;
        fetch(5);
        check("parity_err",  32'(bus.fetch_err), PAR_EN ? 32'h3 : 32'h0);
        check("parity_data", 32'(bus.instr), 32'(ref_mem[5]));

        // Randomized phase against the model.
        mid_cycle_reset();
        for (int n = 0; n < 400; n++) begin
            r_start = ($urandom_range(0, 99) < 2);
            r_en    = !r_start && ($urandom_range(0, 1) == 1);
            r_req   = ($urandom_range(0, 1) == 1);
            r_pc    = $urandom_range(0, 79);
            r_data  = WORD_W'($urandom);
            do_cycle(r_start, r_en, r_data, r_req, r_pc);
        end
        idle_cycle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised instruction memory with a streaming program loader and a registered, handshaked fetch port. It sits between the program counter and the instruction decoder. Each fetch returns the opcode field, the label/immediate field and the raw word, plus an error code. The block adds depth/width parameters, reset-cleared word-valid tracking, out-of-range detection and optional parity checking.

## Interface
Parameters:
- `WORD_W`, 8: instruction word width.
- `ADDR_W`, 8: PC width.
- `DEPTH`, 64: number of words; must satisfy `DEPTH <= 2**ADDR_W`.
- `OP_W`, 4: opcode field width; must satisfy `OP_W <= WORD_W`.
- `LBL_W`, 6: label field width; must satisfy `LBL_W <= WORD_W`.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `load_start`  in  1: rewinds the load pointer to 0 and clears `load_ovf`.
- `load_en`  in  1: write `load_data` at the load pointer.
- `load_data`  in  WORD_W: word to store.
- `load_full`  out  1: load pointer == DEPTH.
- `load_ovf`  out  1: sticky; a write was attempted while full.
- `fetch_req`  in  1: request a fetch of `pc`.
- `fetch_ready`  out  1: combinational, `!load_en && !load_start`.
- `pc`  in  ADDR_W: fetch address.
- `fetch_valid`  out  1: one-cycle pulse when the result is valid.
- `instr`  out  WORD_W: raw fetched word.
- `opcode`  out  OP_W: `instr[WORD_W-1 -: OP_W]`.
- `label`  out  LBL_W: `instr[LBL_W-1:0]`. Overlap with `opcode` bits is allowed and intended.
- `fetch_err`  out  2: 00 ok, 01 out of range, 10 unwritten, 11 parity.

## Operation
- **Storage:** `mem[0:DEPTH-1]` of WORD_W bits. A `written[DEPTH]` bit vector is cleared by reset; `mem` contents are not reset.
- **Load pointer:** `lptr`, ADDR_W+1 bits.
  - Reset or `load_start` sets `lptr` to 0.
  - `load_en` with `lptr < DEPTH`: writes `mem[lptr]`, sets `written[lptr]`, then `lptr++`.
  - `load_en` with `lptr == DEPTH`: ignored; `load_ovf` is set to 1.
  - `load_start` and `load_en` in the same cycle: `load_start` wins and the write is dropped.
- **Fetch acceptance:** a fetch is accepted when `fetch_req && fetch_ready`. Loader activity has priority. A stalled requester holds `pc` and `fetch_req` until it is accepted.
- **Accepted fetch, next edge:**
  - `fetch_valid` = 1.
  - `pc >= DEPTH`: `instr` = 0, `fetch_err` = 01.
  - Otherwise, `!written[pc]`: `instr` = 0, `fetch_err` = 10.
  - Otherwise: `instr` = `mem[pc]`, `fetch_err` = 00.
- **Idle cycles:** with no accepted fetch, `fetch_valid` = 0. `instr`, `opcode`, `label` and `fetch_err` hold their last values.
- **Two-state FSM:**
  - IDLE → RESP on an accepted fetch.
  - RESP → RESP on an accepted fetch (back-to-back fetches allowed).
  - RESP → IDLE otherwise.
  - `fetch_valid` = (state == RESP).
- **Reset values:** `fetch_valid`, `instr`, `opcode`, `label`, `fetch_err`, `load_ovf` and `load_full` are all 0. `lptr` = 0, state = IDLE. Reset asserted mid-load or mid-fetch aborts immediately; the in-flight response is not delivered.

## Timing
- Fetch latency is 1 cycle, from the accept edge to `fetch_valid`. Throughput is 1 fetch per cycle.
- `load_full` and `load_ovf` are registered and update on the edge after the causing write.
- A load write and a fetch never share a cycle, so there is no read-during-write hazard.

## Configuration
- `INSTR_FETCH_MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed on load.
  - A fetch of a written word with mismatched parity returns the stored data with `fetch_err` = 11.
  - Out-of-range and unwritten checks still take precedence.
- Undefined: no parity storage, and code 11 is never produced.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs read 0 immediately and the FSM is in IDLE. A fetch of `pc` = 0 after reset → `fetch_err` = 10, `instr` = 0.
- **Load then fetch:** pulse `load_start`, then load 8'hA5, 8'h3C. Fetch `pc` = 1 → one cycle later `fetch_valid` = 1, `instr` = 8'h3C, `opcode` = 4'h3, `label` = 6'h3C, `fetch_err` = 00.
- **Range and overflow:** with defaults, fetch `pc` = 64 → `fetch_err` = 01. Load 65 words → `load_full` = 1 after the 64th, `load_ovf` = 1 after the 65th, and `mem[0]` is unchanged.
- **Priority and back-to-back:**
  - Hold `fetch_req` while `load_en` = 1 → `fetch_ready` = 0 and no `fetch_valid`; the fetch is accepted on the first cycle with `load_en` = 0.
  - Fetches on 3 consecutive cycles → `fetch_valid` high for 3 consecutive cycles.
- **Parity (macro defined):** force one stored bit flip via hierarchical access, then fetch → `fetch_err` = 11. The same stimulus without the macro → `fetch_err` = 00.
